// File: rtl/rotor_quad_decoder.sv
// Quadrature rotary-encoder decoder: synchronises and debounces ROT_A/ROT_B, decodes the
// Gray sequence into step pulses, keeps a signed position and a sticky illegal-transition flag.
module rotor_quad_decoder #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_MODE      = 0,
    parameter int SATURATE        = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ROT_A,
    input  logic                    ROT_B,
    input  logic                    pos_clr,
    input  logic                    err_clr,
    output logic                    rotation_event,
    output logic                    rotation_direction,
    output logic                    step_valid,
    output logic                    step_dir,
    output logic signed [WIDTH-1:0] position,
    output logic                    illegal_err
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] POS_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        TRACK  = 1'b0,
        RESYNC = 1'b1
    } state_t;

    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        case (ab)
            2'b11:   fwd_next = 2'b01;
            2'b01:   fwd_next = 2'b00;
            2'b00:   fwd_next = 2'b10;
            default: fwd_next = 2'b11;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] pos_step(
        input logic signed [WIDTH-1:0] pos,
        input logic                    up
    );
        if (SATURATE != 0 && up && pos == POS_MAX)
            pos_step = POS_MAX;
        else if (SATURATE != 0 && !up && pos == POS_MIN)
            pos_step = POS_MIN;
        else if (up)
            pos_step = pos + 1'b1;
        else
            pos_step = pos - 1'b1;
    endfunction

    // Stage p0/p1: two-flop synchroniser, bit 1 = A, bit 0 = B
    logic [1:0] sync_p0;
    logic [1:0] sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
        end else begin
            sync_p0 <= {ROT_A, ROT_B};
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: per-phase debounce, filt follows sync after DEBOUNCE_CYCLES mismatching cycles
    logic [1:0]       filt_p2;
    logic [CNT_W-1:0] cnt_p2 [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_p2   <= 2'b11;
            cnt_p2[0] <= '0;
            cnt_p2[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == filt_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] == CNT_LAST) begin
                    filt_p2[i] <= sync_p1[i];
                    cnt_p2[i]  <= '0;
                end else begin
                    cnt_p2[i] <= cnt_p2[i] + 1'b1;
                end
            end
        end
    end

    // Stage p3: sequence decode against the previous filtered value, registered outputs
    logic [1:0]        prev_p3;
    state_t            state_p3;
    logic signed [2:0] q_p3;
    logic              is_fwd;
    logic              is_rev;
    logic              is_bad;
    logic signed [3:0] q_nxt;
    logic              step_hit;

    assign is_fwd = (filt_p2 == fwd_next(prev_p3));
    assign is_rev = (prev_p3 == fwd_next(filt_p2));
    assign is_bad = ((filt_p2 ^ prev_p3) == 2'b11);
    // One extra bit so a full detent (+/-4) is representable before q is cleared at 11
    assign q_nxt  = is_fwd ? ({q_p3[2], q_p3} + 4'sd1) : ({q_p3[2], q_p3} - 4'sd1);

    always_comb begin
        step_hit = 1'b0;
        if (state_p3 == TRACK && (is_fwd || is_rev)) begin
            if (COUNT_MODE != 0)
                step_hit = 1'b1;
            else if (filt_p2 == 2'b11)
                step_hit = (q_nxt == 4'sd4) || (q_nxt == -4'sd4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_p3            <= 2'b11;
            state_p3           <= TRACK;
            q_p3               <= 3'sd0;
            step_valid         <= 1'b0;
            step_dir           <= 1'b0;
            position           <= '0;
            illegal_err        <= 1'b0;
            rotation_event     <= 1'b0;
            rotation_direction <= 1'b0;
        end else begin
            prev_p3 <= filt_p2;

            if (filt_p2 == 2'b11)
                rotation_event <= 1'b1;
            else if (filt_p2 == 2'b00)
                rotation_event <= 1'b0;

            if (filt_p2 == 2'b01)
                rotation_direction <= 1'b1;
            else if (filt_p2 == 2'b10)
                rotation_direction <= 1'b0;

            step_valid <= step_hit;
            if (step_hit)
                step_dir <= is_fwd;

            if (pos_clr)
                position <= '0;
            else if (step_hit)
                position <= pos_step(position, is_fwd);

            if (is_bad)
                illegal_err <= 1'b1;
            else if (err_clr)
                illegal_err <= 1'b0;

            case (state_p3)
                TRACK: begin
                    if (is_bad) begin
                        q_p3     <= 3'sd0;
                        state_p3 <= RESYNC;
                    end else if (is_fwd || is_rev) begin
                        q_p3 <= (COUNT_MODE == 0 && filt_p2 != 2'b11) ? q_nxt[2:0] : 3'sd0;
                    end
                end
                default: begin
                    if (!is_bad && filt_p2 == 2'b11) begin
                        q_p3     <= 3'sd0;
                        state_p3 <= TRACK;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_quad_decoder.sv
// Bench for rotor_quad_decoder: four parameter variants share one stimulus and are checked
// every cycle against a Gray-index reference model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_rotor_quad_decoder;

    localparam int N = 4;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic ra      = 1'b1;
    logic rb      = 1'b1;
    logic pos_clr = 1'b0;
    logic err_clr = 1'b0;

    logic o_ev  [N];
    logic o_rd  [N];
    logic o_sv  [N];
    logic o_dir [N];
    logic o_err [N];
    logic signed [7:0] pos0;
    logic signed [3:0] pos1;
    logic signed [3:0] pos2;
    logic signed [7:0] pos3;

    int n_vec  = 0;
    int n_fail = 0;
    int pulses [N] = '{default: 0};

    logic [1:0] seq [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

    always #5 clk = ~clk;

    rotor_quad_decoder #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .COUNT_MODE(0), .SATURATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .ROT_A(ra), .ROT_B(rb), .pos_clr(pos_clr), .err_clr(err_clr),
        .rotation_event(o_ev[0]), .rotation_direction(o_rd[0]), .step_valid(o_sv[0]),
        .step_dir(o_dir[0]), .position(pos0), .illegal_err(o_err[0]));
    rotor_quad_decoder #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .COUNT_MODE(0), .SATURATE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .ROT_A(ra), .ROT_B(rb), .pos_clr(pos_clr), .err_clr(err_clr),
        .rotation_event(o_ev[1]), .rotation_direction(o_rd[1]), .step_valid(o_sv[1]),
        .step_dir(o_dir[1]), .position(pos1), .illegal_err(o_err[1]));
    rotor_quad_decoder #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .COUNT_MODE(0), .SATURATE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .ROT_A(ra), .ROT_B(rb), .pos_clr(pos_clr), .err_clr(err_clr),
        .rotation_event(o_ev[2]), .rotation_direction(o_rd[2]), .step_valid(o_sv[2]),
        .step_dir(o_dir[2]), .position(pos2), .illegal_err(o_err[2]));
    rotor_quad_decoder #(.WIDTH(8), .DEBOUNCE_CYCLES(3), .COUNT_MODE(1), .SATURATE(0)) u3 (
        .clk(clk), .rst_n(rst_n), .ROT_A(ra), .ROT_B(rb), .pos_clr(pos_clr), .err_clr(err_clr),
        .rotation_event(o_ev[3]), .rotation_direction(o_rd[3]), .step_valid(o_sv[3]),
        .step_dir(o_dir[3]), .position(pos3), .illegal_err(o_err[3]));

    function automatic int pw(input int i);
        return (i == 1 || i == 2) ? 4 : 8;
    endfunction
    function automatic int pd(input int i);
        return (i == 3) ? 3 : 4;
    endfunction
    function automatic bit pm(input int i);
        return i == 3;
    endfunction
    function automatic bit ps(input int i);
        return i == 2;
    endfunction

    function automatic int act_pos(input int i);
        case (i)
            0:       return int'(pos0);
            1:       return int'(pos1);
            2:       return int'(pos2);
            default: return int'(pos3);
        endcase
    endfunction

    // Position of an AB pattern along the forward Gray cycle 11,01,00,10
    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b11:   return 0;
            2'b01:   return 1;
            2'b00:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [1:0] m_s0 [N];
    logic [1:0] m_s1 [N];
    logic [1:0] m_filt [N];
    logic [1:0] m_prev [N];
    logic [1:0] m_hist [N][8];
    int         m_hcnt [N];
    bit         m_track [N];
    int         m_acc [N];
    int         m_pos [N];
    bit         m_ev [N];
    bit         m_rd [N];
    bit         m_sv [N];
    bit         m_dir [N];
    bit         m_err [N];

    task automatic model_reset(input int i);
        m_s0[i] = 2'b11; m_s1[i] = 2'b11; m_filt[i] = 2'b11; m_prev[i] = 2'b11;
        m_hcnt[i] = 0; m_track[i] = 1'b1; m_acc[i] = 0; m_pos[i] = 0;
        m_ev[i] = 0; m_rd[i] = 0; m_sv[i] = 0; m_dir[i] = 0; m_err[i] = 0;
    endtask

    task automatic model_step(input int i);
        logic [1:0] nf;
        int d;
        bit up;
        int hi;
        int lo;
        d  = (gidx(m_filt[i]) - gidx(m_prev[i]) + 4) % 4;
        up = (d == 1);
        m_sv[i] = 1'b0;
        if (d == 2) begin
            m_err[i] = 1'b1; m_track[i] = 1'b0; m_acc[i] = 0;
        end else begin
            if (err_clr) m_err[i] = 1'b0;
            if (!m_track[i]) begin
                if (m_filt[i] == 2'b11) begin m_track[i] = 1'b1; m_acc[i] = 0; end
            end else if (d != 0) begin
                if (pm(i)) begin
                    m_sv[i] = 1'b1;
                end else begin
                    m_acc[i] += up ? 1 : -1;
                    if (m_filt[i] == 2'b11) begin
                        m_sv[i]  = (m_acc[i] == 4 || m_acc[i] == -4);
                        m_acc[i] = 0;
                    end
                end
            end
        end
        if (m_sv[i]) m_dir[i] = up;
        hi = (1 << (pw(i) - 1)) - 1;
        lo = -(1 << (pw(i) - 1));
        if (pos_clr) begin
            m_pos[i] = 0;
        end else if (m_sv[i]) begin
            m_pos[i] += up ? 1 : -1;
            if (m_pos[i] > hi) m_pos[i] = ps(i) ? hi : lo;
            if (m_pos[i] < lo) m_pos[i] = ps(i) ? lo : hi;
        end
        if (m_filt[i] == 2'b11) m_ev[i] = 1'b1; else if (m_filt[i] == 2'b00) m_ev[i] = 1'b0;
        if (m_filt[i] == 2'b01) m_rd[i] = 1'b1; else if (m_filt[i] == 2'b10) m_rd[i] = 1'b0;
        m_prev[i] = m_filt[i];
        // A filtered bit flips once the last D synchronised samples all disagree with it
        for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = m_s1[i];
        if (m_hcnt[i] < 8) m_hcnt[i]++;
        nf = m_filt[i];
        for (int b = 0; b < 2; b++) begin
            bit flip;
            flip = (m_hcnt[i] >= pd(i));
            for (int k = 0; k < pd(i); k++)
                if (m_hist[i][k][b] == m_filt[i][b]) flip = 1'b0;
            if (flip) nf[b] = ~m_filt[i][b];
        end
        m_filt[i] = nf;
        m_s1[i] = m_s0[i];
        m_s0[i] = {ra, rb};
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < N; i++) begin
            if (!rst_n) model_reset(i);
            else        model_step(i);
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d.step_valid", i), int'(o_sv[i]), int'(m_sv[i]));
            check($sformatf("u%0d.step_dir", i), int'(o_dir[i]), int'(m_dir[i]));
            check($sformatf("u%0d.position", i), act_pos(i), m_pos[i]);
            check($sformatf("u%0d.illegal_err", i), int'(o_err[i]), int'(m_err[i]));
            check($sformatf("u%0d.rotation_event", i), int'(o_ev[i]), int'(m_ev[i]));
            check($sformatf("u%0d.rotation_direction", i), int'(o_rd[i]), int'(m_rd[i]));
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (o_sv[i] === 1'b1) pulses[i]++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running, expected to finish");
        $fatal(1, "timeout");
    end

    task automatic move(input logic [1:0] ab, input int hold);
        {ra, rb} = ab;
        repeat (hold) @(negedge clk);
    endtask

    task automatic fwd_cycle(input int hold);
        move(2'b01, hold); move(2'b00, hold); move(2'b10, hold); move(2'b11, hold);
    endtask

    initial begin
        int s0, s3, lat, p3, hold, r;
        logic [1:0] cur, nxt;

        // Reset with inputs toggling, then idle at 11
        ra = 1'b0; rb = 1'b0;
        repeat (6) begin @(negedge clk); ra = ~ra; rb = ~rb; end
        check("rst.step_valid", int'(o_sv[0]), 0);
        check("rst.position", act_pos(0), 0);
        check("rst.illegal_err", int'(o_err[0]), 0);
        check("rst.rotation_event", int'(o_ev[0]), 0);
        check("rst.rotation_direction", int'(o_rd[0]), 0);
        ra = 1'b1; rb = 1'b1; rst_n = 1'b1;
        s0 = pulses[0];
        move(2'b11, 50);
        check("idle.pulses", pulses[0] - s0, 0);
        check("idle.rotation_event", int'(o_ev[0]), 1);

        // One forward detent with pulse latency, then the mirror
        s0 = pulses[0]; s3 = pulses[3];
        move(2'b01, 20); move(2'b00, 20); move(2'b10, 20);
        {ra, rb} = 2'b11;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (o_sv[0]) begin lat = k; break; end
        end
        check("fwd.latency", lat, 7);
        repeat (20) @(negedge clk);
        check("fwd.position", act_pos(0), 1);
        check("fwd.model_position", m_pos[0], 1);
        check("fwd.step_dir", int'(o_dir[0]), 1);
        check("fwd.pulses", pulses[0] - s0, 1);
        check("x4.pulses", pulses[3] - s3, 4);
        check("x4.position", act_pos(3), 4);
        move(2'b10, 20); move(2'b00, 20); move(2'b01, 20); move(2'b11, 20);
        check("rev.position", act_pos(0), 0);
        check("rev.step_dir", int'(o_dir[0]), 0);
        check("rev.x4_position", act_pos(3), 0);

        // Bounce on A shorter than the debounce window
        s0 = pulses[0]; s3 = pulses[3];
        for (int k = 0; k < 6; k++) begin ra = ~ra; repeat (2) @(negedge clk); end
        repeat (20) @(negedge clk);
        check("bounce.pulses", pulses[0] - s0, 0);
        check("bounce.x4_pulses", pulses[3] - s3, 0);
        check("bounce.rotation_event", int'(o_ev[0]), 1);
        check("bounce.rotation_direction", int'(o_rd[0]), 1);

        // Partial reversal, then an illegal jump and recovery
        s0 = pulses[0];
        move(2'b01, 20); move(2'b00, 20); move(2'b01, 20); move(2'b11, 20);
        check("partial.pulses", pulses[0] - s0, 0);
        check("partial.x4_position", act_pos(3), 0);
        move(2'b00, 20);
        check("illegal.err", int'(o_err[0]), 1);
        check("illegal.x4_err", int'(o_err[3]), 1);
        s3 = pulses[3];
        move(2'b10, 20); move(2'b11, 20);
        check("resync.pulses", pulses[0] - s0, 0);
        check("resync.x4_pulses", pulses[3] - s3, 0);
        fwd_cycle(20);
        check("recover.position", act_pos(0), 1);
        check("recover.x4_position", act_pos(3), 4);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0; @(negedge clk);
        check("err_clr.err", int'(o_err[0]), 0);

        // Position limits on the 4-bit variants
        rst_n = 1'b0; repeat (3) @(negedge clk); rst_n = 1'b1; repeat (5) @(negedge clk);
        repeat (7) fwd_cycle(12);
        check("lim.wrap_at_max", act_pos(1), 7);
        check("lim.sat_at_max", act_pos(2), 7);
        fwd_cycle(12);
        check("lim.wrap", act_pos(1), -8);
        check("lim.model_wrap", m_pos[1], -8);
        check("lim.sat", act_pos(2), 7);
        move(2'b01, 12); move(2'b00, 12); move(2'b10, 12);
        {ra, rb} = 2'b11;
        repeat (6) @(negedge clk);
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        check("clr.step_valid", int'(o_sv[0]), 1);
        check("clr.position_u0", act_pos(0), 0);
        check("clr.position_u1", act_pos(1), 0);
        check("clr.position_u2", act_pos(2), 0);
        repeat (12) @(negedge clk);

        // x4 jitter 11,01,11 nets to zero
        s0 = pulses[0]; s3 = pulses[3]; p3 = act_pos(3);
        move(2'b01, 20); move(2'b11, 20);
        check("jitter.x4_pulses", pulses[3] - s3, 2);
        check("jitter.x4_position", act_pos(3), p3);
        check("jitter.x1_pulses", pulses[0] - s0, 0);

        // Randomised rotation with glitches, illegal jumps, clears and one mid-run reset
        cur = 2'b11;
        for (int it = 0; it < 1500; it++) begin
            r = int'($urandom_range(0, 99));
            hold = int'($urandom_range(1, 14));
            if (r < 40)      nxt = seq[(gidx(cur) + 1) % 4];
            else if (r < 75) nxt = seq[(gidx(cur) + 3) % 4];
            else if (r < 80) nxt = cur ^ 2'b11;
            else             nxt = cur ^ (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
            pos_clr = ($urandom_range(0, 29) == 0);
            err_clr = ($urandom_range(0, 19) == 0);
            {ra, rb} = nxt;
            @(negedge clk);
            pos_clr = 1'b0; err_clr = 1'b0;
            if (r >= 80) begin
                repeat (int'($urandom_range(0, 2))) @(negedge clk);
                {ra, rb} = cur;
            end else begin
                cur = nxt;
            end
            repeat (hold - 1) @(negedge clk);
            if (it == 700) begin
                rst_n = 1'b0; repeat (2) @(negedge clk); rst_n = 1'b1;
            end
        end
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
